// File: rtl/cacheline_adapter_pkg.sv
// cacheline_adapter_pkg: state encoding and line/burst geometry shared by the adapter files.
package cacheline_adapter_pkg;
    localparam int BEATS = 4;
    localparam int BEAT_WIDTH = 64;
    localparam int LINE_WIDTH = BEATS * BEAT_WIDTH;
    localparam int OFFSET_BITS = 5;
    localparam int CNT_BITS = $clog2(BEATS);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adapter_state_t;
endpackage

// File: rtl/cacheline_adapter_if.sv
// cacheline_adapter_if: cache-side line port plus memory-side burst port of the adapter.
interface cacheline_adapter_if;
    import cacheline_adapter_pkg::*;
    logic [31:0] mem_address;
    logic mem_read;
    logic mem_write;
    logic [LINE_WIDTH-1:0] mem_wdata256;
    logic [LINE_WIDTH-1:0] mem_rdata256;
    logic mem_resp;
    logic [31:0] pmem_address;
    logic pmem_read;
    logic pmem_write;
    logic [BEAT_WIDTH-1:0] pmem_wdata;
    logic [BEAT_WIDTH-1:0] pmem_rdata;
    logic pmem_resp;
    modport master (
        output mem_address, mem_read, mem_write, mem_wdata256, pmem_rdata, pmem_resp,
        input mem_rdata256, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
    modport slave (
        input mem_address, mem_read, mem_write, mem_wdata256, pmem_rdata, pmem_resp,
        output mem_rdata256, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/cacheline_adapter_beat_counter.sv
// cacheline_adapter_beat_counter: beat index within a burst, wraps at the last beat.
module cacheline_adapter_beat_counter
    import cacheline_adapter_pkg::*;
(
    input logic clk,
    input logic rst,
    input logic clr_i,
    input logic en_i,
    output logic [CNT_BITS-1:0] cnt_o
);
    logic [CNT_BITS-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + CNT_BITS'(1);
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: turns one 256-bit line read/writeback into a 4 x 64-bit memory burst.
// Define CACHELINE_ADAPTER_FAST_RESP_EN to complete reads in the cycle the last beat arrives.
module cacheline_adapter
    import cacheline_adapter_pkg::*;
(
    input logic clk,
    input logic rst,
    cacheline_adapter_if.slave bus
);
    adapter_state_t state_q, state_d;
    logic [31:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q, line_q;
    logic [CNT_BITS-1:0] cnt;
    logic busy, beat, last, fast_resp;

    assign busy = (state_q == READ) || (state_q == WRITE);
    assign beat = busy && bus.pmem_resp;
    assign last = beat && (cnt == CNT_BITS'(BEATS - 1));

    cacheline_adapter_beat_counter u_cnt (
        .clk(clk),
        .rst(rst),
        .clr_i(state_q == IDLE),
        .en_i(beat),
        .cnt_o(cnt)
    );

`ifdef CACHELINE_ADAPTER_FAST_RESP_EN
    assign fast_resp = last && (state_q == READ);
`else
    assign fast_resp = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = bus.mem_read ? READ : bus.mem_write ? WRITE : IDLE;
            READ: state_d = fast_resp ? IDLE : last ? DONE : READ;
            WRITE: state_d = last ? DONE : WRITE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are sampled every idle cycle, so the value kept is the one seen on leaving IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            wdata_q <= '0;
            line_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                addr_q <= bus.mem_address & LINE_MASK;
                wdata_q <= bus.mem_wdata256;
            end
            if (beat && state_q == READ) line_q[cnt*BEAT_WIDTH +: BEAT_WIDTH] <= bus.pmem_rdata;
        end
    end

    always_comb begin
        bus.pmem_read = state_q == READ;
        bus.pmem_write = state_q == WRITE;
        bus.pmem_address = busy ? addr_q : '0;
        bus.pmem_wdata = (state_q == WRITE) ? wdata_q[cnt*BEAT_WIDTH +: BEAT_WIDTH] : '0;
        bus.mem_resp = (state_q == DONE) || fast_resp;
        bus.mem_rdata256 = fast_resp ? {bus.pmem_rdata, line_q[LINE_WIDTH-BEAT_WIDTH-1:0]} : line_q;
    end
endmodule
